// File: rtl/filter_pkg.sv
// Shared definitions for the filter-selection path.
// filter_e is also imported by the downstream filter mux, so the encoding of
// each filter index must stay stable. The KEY_* constants name the key
// positions that the cycle mode uses.
package filter_pkg;

  typedef enum logic [1:0] {
    COLOUR     = 2'd0,
    BLUR       = 2'd1,
    BRIGHTNESS = 2'd2,
    EDGES      = 2'd3
  } filter_e;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_CYCLE  = 1'b1
  } mode_e;

  localparam int unsigned KEY_NEXT = 0;
  localparam int unsigned KEY_PREV = 1;
  localparam int unsigned KEY_HOME = 2;

endpackage

// File: rtl/filter_select_fsm_if.sv
// Bus between the button/mode inputs and the filter-select outputs.
//   key            raw buttons, active-low, asynchronous
//   cycle_mode     0 = direct, 1 = cycle
//   lock           1 = ignore key presses
//   filter_type    registered current filter index
//   filter_onehot  registered one-hot copy of filter_type
//   filter_changed one-cycle pulse when filter_type changes
// slave: the selection controller. master: whatever drives the keys and
// consumes the selection.
interface filter_select_fsm_if #(
  parameter int NUM_KEYS    = 4,
  parameter int NUM_FILTERS = 4,
  parameter int SEL_W       = $clog2(NUM_FILTERS)
);
  logic [NUM_KEYS-1:0]    key;
  logic                   cycle_mode;
  logic                   lock;
  logic [SEL_W-1:0]       filter_type;
  logic [NUM_FILTERS-1:0] filter_onehot;
  logic                   filter_changed;

  modport master (
    output key, cycle_mode, lock,
    input  filter_type, filter_onehot, filter_changed
  );

  modport slave (
    input  key, cycle_mode, lock,
    output filter_type, filter_onehot, filter_changed
  );
endinterface

// File: rtl/key_conditioner.sv
// Conditions one raw active-low push-button.
//   clk, reset  system clock, synchronous active-high reset
//   key_n       raw button level (0 = pressed), asynchronous
//   pressed     debounced level (1 = pressed)
//   press_edge  one-cycle pulse when the debounced level becomes pressed
// Path: 2-FF synchroniser -> counter debounce -> press-edge detect.
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic press_edge
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  // The synchroniser preload contributes two "released" samples after
  // reset that do not come from the pin, so arming waits for two more.
  localparam int unsigned ARM_LIMIT = DEBOUNCE_CYCLES + 2;
  localparam int unsigned ARM_W = $clog2(ARM_LIMIT + 1);
  localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(ARM_LIMIT);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             pressed_q;
  logic             prev_q;
  logic             armed;
  logic [ARM_W-1:0] arm_cnt;
  logic             level_pressed;
  logic             toggle;

  assign level_pressed = ~sync2;
  assign toggle        = (level_pressed != pressed_q) && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      cnt       <= '0;
      pressed_q <= 1'b0;
      prev_q    <= 1'b0;
      armed     <= 1'b0;
      arm_cnt   <= '0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;

      if (level_pressed == pressed_q) begin
        cnt <= '0;
      end else if (toggle) begin
        pressed_q <= ~pressed_q;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      prev_q <= pressed_q;

      // After reset, presses are blocked until the key has been seen
      // released: either a debounced release, or a debounce-length run of
      // released samples. A key held through reset thus needs a fresh press.
      if (!armed) begin
        if (toggle && pressed_q) begin
          armed <= 1'b1;
        end else if (!pressed_q && !level_pressed) begin
          if (arm_cnt == ARM_MAX) begin
            armed <= 1'b1;
          end else begin
            arm_cnt <= arm_cnt + ARM_W'(1);
          end
        end else begin
          arm_cnt <= '0;
        end
      end
    end
  end

  assign pressed    = pressed_q;
  assign press_edge = pressed_q & ~prev_q & armed;

endmodule

// File: rtl/filter_select_fsm.sv
// Filter-selection controller for the video pipeline.
//   clk, reset  system clock, synchronous active-high reset
//   bus         filter_select_fsm_if.slave: keys, cycle_mode and lock in;
//               filter_type, filter_onehot and filter_changed out
// Each key is conditioned into a press pulse. Direct mode maps key i to
// filter i (lowest index wins). Cycle mode steps next/previous with
// wrap-around, and home returns to RESET_FILTER. lock discards presses.
module filter_select_fsm
  import filter_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned NUM_FILTERS     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned RESET_FILTER    = 0,
  parameter int unsigned SEL_W           = $clog2(NUM_FILTERS)
) (
  input  logic              clk,
  input  logic              reset,
  filter_select_fsm_if.slave bus
);

  localparam logic [SEL_W-1:0] RST_SEL   = SEL_W'(RESET_FILTER);
  localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NUM_FILTERS - 1);
  localparam logic [SEL_W:0]   SEL_LIMIT = (SEL_W + 1)'(NUM_FILTERS);
  localparam logic [NUM_FILTERS-1:0] RST_ONEHOT =
    NUM_FILTERS'(1) << RESET_FILTER;

  // Debounced levels are not needed for selection, only the press pulses.
  logic [NUM_KEYS-1:0]    held_unused;
  logic [NUM_KEYS-1:0]    press_edge;
  logic [NUM_KEYS-1:0]    edges;
  logic [NUM_KEYS-1:0]    scan;
  logic                   hit;
  mode_e                  mode;
  logic [SEL_W-1:0]       current_sel;
  logic [SEL_W-1:0]       next_sel;
  logic [NUM_FILTERS-1:0] onehot_q;
  logic [NUM_FILTERS-1:0] onehot_next;
  logic                   changed_q;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk       (clk),
      .reset     (reset),
      .key_n     (bus.key[i]),
      .pressed   (held_unused[i]),
      .press_edge(press_edge[i])
    );
  end

  always_comb begin
    mode     = mode_e'(bus.cycle_mode);
    edges    = press_edge & ~{NUM_KEYS{bus.lock}};
    next_sel = current_sel;
    hit      = 1'b0;
    scan     = edges;

    if ({1'b0, current_sel} >= SEL_LIMIT) begin
      next_sel = RST_SEL;
    end else if (mode == MODE_CYCLE) begin
      if (edges[KEY_HOME]) begin
        next_sel = RST_SEL;
      end else if (edges[KEY_NEXT] && !edges[KEY_PREV]) begin
        next_sel = (current_sel == LAST_SEL) ? '0 : current_sel + SEL_W'(1);
      end else if (edges[KEY_PREV] && !edges[KEY_NEXT]) begin
        next_sel = (current_sel == '0) ? LAST_SEL : current_sel - SEL_W'(1);
      end
    end else begin
      // Scan from key 0 upward so the lowest pressed index wins.
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        if (!hit && scan[0] && (i < NUM_FILTERS)) begin
          next_sel = SEL_W'(i);
          hit      = 1'b1;
        end
        scan = scan >> 1;
      end
    end

    onehot_next = NUM_FILTERS'(1) << next_sel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      current_sel <= RST_SEL;
      onehot_q    <= RST_ONEHOT;
      changed_q   <= 1'b0;
    end else begin
      current_sel <= next_sel;
      onehot_q    <= onehot_next;
      changed_q   <= (next_sel != current_sel);
    end
  end

  assign bus.filter_type    = current_sel;
  assign bus.filter_onehot  = onehot_q;
  assign bus.filter_changed = changed_q;

endmodule

// File: tb/tb_filter_select_fsm.sv
module tb_filter_select_fsm;

  localparam int NK = 4;
  localparam int NF = 4;
  localparam int DB = 4;
  localparam int RF = 0;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   pulses = 0;
  int   p0;

  filter_select_fsm_if #(.NUM_KEYS(NK), .NUM_FILTERS(NF)) bus ();

  filter_select_fsm #(
    .NUM_KEYS       (NK),
    .NUM_FILTERS    (NF),
    .DEBOUNCE_CYCLES(DB),
    .RESET_FILTER   (RF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.filter_changed === 1'b1) pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Press the keys in mask for 8 edges (enough for a press to land),
  // check the selection, release for 8 edges, check pulse count.
  task automatic press_release(input logic [3:0] mask, input logic [1:0] exp_sel,
                               input int exp_pulses, input string tag);
    int start;
    start = pulses;
    bus.key = ~mask;
    step(8);
    check({tag, "_sel"}, 32'(bus.filter_type), 32'(exp_sel));
    bus.key = '1;
    step(8);
    check({tag, "_pulses"}, 32'(pulses - start), 32'(exp_pulses));
  endtask

  initial begin
    reset          = 1'b1;
    bus.key        = '1;
    bus.cycle_mode = 1'b0;
    bus.lock       = 1'b0;
    step(2);
    reset = 1'b0;
    check("rst_type", 32'(bus.filter_type), 32'd0);
    check("rst_onehot", 32'(bus.filter_onehot), 32'b0001);
    check("rst_changed", 32'(bus.filter_changed), 32'd0);

    // Direct press of key[2], first sampled at edge 10 -> update at edge 17.
    step(7);
    p0 = pulses;
    bus.key = 4'b1011;
    step(7);
    check("lat_e16_type", 32'(bus.filter_type), 32'd0);
    check("lat_e16_changed", 32'(bus.filter_changed), 32'd0);
    step(1);
    check("lat_e17_type", 32'(bus.filter_type), 32'd2);
    check("lat_e17_onehot", 32'(bus.filter_onehot), 32'b0100);
    check("lat_e17_changed", 32'(bus.filter_changed), 32'd1);
    step(1);
    check("lat_e18_changed", 32'(bus.filter_changed), 32'd0);
    check("lat_pulses", 32'(pulses - p0), 32'd1);
    bus.key = '1;
    step(8);

    // Bounce on key[1]: low runs too short to debounce.
    p0 = pulses;
    repeat (4) begin
      bus.key = 4'b1101;
      step(3);
      bus.key = '1;
      step(2);
    end
    step(10);
    check("bounce_type", 32'(bus.filter_type), 32'd2);
    check("bounce_pulses", 32'(pulses - p0), 32'd0);

    // Cycle mode stepping.
    press_release(4'b1000, 2'd3, 1, "direct3");
    bus.cycle_mode = 1'b1;
    step(1);
    check("mode_sw_type", 32'(bus.filter_type), 32'd3);
    check("mode_sw_changed", 32'(bus.filter_changed), 32'd0);
    press_release(4'b0001, 2'd0, 1, "next_wrap");
    press_release(4'b0010, 2'd3, 1, "prev_wrap");
    press_release(4'b0011, 2'd3, 0, "next_prev");
    press_release(4'b0010, 2'd2, 1, "prev");
    press_release(4'b0101, 2'd0, 1, "home_wins");
    press_release(4'b0100, 2'd0, 0, "home_again");

    // Lock: presses discarded, not queued.
    bus.cycle_mode = 1'b0;
    step(1);
    p0 = pulses;
    bus.lock = 1'b1;
    bus.key  = 4'b0111;
    step(10);
    check("lock_held_type", 32'(bus.filter_type), 32'd0);
    bus.lock = 1'b0;
    step(5);
    check("unlock_held_type", 32'(bus.filter_type), 32'd0);
    check("lock_pulses", 32'(pulses - p0), 32'd0);
    bus.key = '1;
    step(8);
    bus.key = 4'b0111;
    step(7);
    check("relock_early", 32'(bus.filter_type), 32'd0);
    step(1);
    check("relock_type", 32'(bus.filter_type), 32'd3);
    check("relock_onehot", 32'(bus.filter_onehot), 32'b1000);
    check("relock_changed", 32'(bus.filter_changed), 32'd1);
    bus.key = '1;
    step(8);

    // Simultaneous direct presses resolve to the lowest index.
    press_release(4'b0110, 2'd1, 1, "direct_prio");

    // Reset two edges before a press would land, key held through reset.
    p0 = pulses;
    bus.key = 4'b1011;
    step(5);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    check("midrst_type", 32'(bus.filter_type), 32'd0);
    check("midrst_onehot", 32'(bus.filter_onehot), 32'b0001);
    check("midrst_changed", 32'(bus.filter_changed), 32'd0);
    step(12);
    check("held_rst_type", 32'(bus.filter_type), 32'd0);
    check("held_rst_pulses", 32'(pulses - p0), 32'd0);
    bus.key = '1;
    step(10);
    press_release(4'b0100, 2'd2, 1, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
